// File: rtl/irrigation_zone_scheduler.sv
// rtl/irrigation_zone_scheduler.sv - periodic multi-zone irrigation scheduler
// Shares one ADC mux and one pump across NUM_ZONES valves; measures, waters in bursts, latches faults.
module irrigation_zone_scheduler #(
    parameter int NUM_ZONES    = 4,
    parameter int DATA_W       = 10,
    parameter int PERIOD       = 100000,
    parameter int SETTLE       = 64,
    parameter int WATER_CYCLES = 50000,
    parameter int MAX_TRIES    = 3,
    parameter int ADC_TIMEOUT  = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic [DATA_W-1:0]            i_threshold,
    input  logic                         i_fault_clr,
    output logic                         o_adc_start,
    output logic [$clog2(NUM_ZONES)-1:0] o_adc_ch,
    input  logic                         i_adc_done,
    input  logic [DATA_W-1:0]            i_adc_data,
    output logic [NUM_ZONES-1:0]         o_valve_en,
    output logic                         o_pump_on,
    output logic                         o_busy,
    output logic                         o_scan_done,
    output logic                         o_overrun,
    output logic [NUM_ZONES-1:0]         o_zone_fault
);

    localparam int ZW     = $clog2(NUM_ZONES);
    localparam int PW     = $clog2(PERIOD);
    localparam int TMAX_A = (SETTLE > WATER_CYCLES) ? SETTLE : WATER_CYCLES;
    localparam int TMAX   = (TMAX_A > ADC_TIMEOUT) ? TMAX_A : ADC_TIMEOUT;
    localparam int TW     = $clog2(TMAX);
    localparam int TRW    = $clog2(MAX_TRIES + 1);

    localparam logic [PW-1:0]  P_LAST      = PW'(PERIOD - 1);
    localparam logic [ZW-1:0]  Z_LAST      = ZW'(NUM_ZONES - 1);
    localparam logic [TW-1:0]  T_ADC_LAST  = TW'(ADC_TIMEOUT - 1);
    localparam logic [TW-1:0]  T_SET_LAST  = TW'(SETTLE - 1);
    localparam logic [TW-1:0]  T_WAT_LAST  = TW'(WATER_CYCLES - 1);
    localparam logic [TRW-1:0] TRY_MAX     = TRW'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_EVAL, S_OPEN, S_WATER, S_NEXT
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ZW-1:0]       r_zone, w_zone_nxt;
    logic [TRW-1:0]      r_tries, w_tries_nxt;
    logic [DATA_W-1:0]   r_sample, w_sample_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic [PW-1:0]       r_period_cnt;
    logic [NUM_ZONES-1:0] r_zone_fault;
    logic                w_fault_set;
    logic                w_tick;
    logic [NUM_ZONES-1:0] w_zone_onehot;

    assign w_tick        = i_enable && (r_period_cnt == P_LAST);
    assign w_zone_onehot = {{(NUM_ZONES-1){1'b0}}, 1'b1} << r_zone;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_zone       <= '0;
            r_tries      <= '0;
            r_sample     <= '0;
            r_timer      <= '0;
            r_period_cnt <= '0;
            r_zone_fault <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_zone   <= w_zone_nxt;
            r_tries  <= w_tries_nxt;
            r_sample <= w_sample_nxt;
            r_timer  <= w_timer_nxt;
            if (!i_enable || r_period_cnt == P_LAST)
                r_period_cnt <= '0;
            else
                r_period_cnt <= r_period_cnt + 1'b1;
            // A fault set in the same cycle as a clear survives the clear.
            r_zone_fault <= (i_fault_clr ? '0 : r_zone_fault) |
                            (w_fault_set ? w_zone_onehot : '0);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_zone_nxt   = r_zone;
        w_tries_nxt  = r_tries;
        w_sample_nxt = r_sample;
        w_timer_nxt  = r_timer;
        w_fault_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_REQ;
                    w_zone_nxt  = '0;
                    w_tries_nxt = '0;
                end
            end
            S_REQ: begin
                if (r_zone_fault[r_zone]) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_adc_done) begin
                    w_sample_nxt = i_adc_data;
                    w_state_nxt  = S_EVAL;
                end else if (r_timer == T_ADC_LAST) begin
                    w_fault_set = 1'b1;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_EVAL: begin
                w_timer_nxt = '0;
                if (r_sample >= i_threshold) begin
                    w_state_nxt = S_NEXT;
                end else if (r_tries < TRY_MAX) begin
                    w_tries_nxt = r_tries + 1'b1;
                    w_state_nxt = S_OPEN;
                end else begin
                    w_fault_set = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_OPEN: begin
                if (r_timer == T_SET_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WATER;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_WATER: begin
                if (r_timer == T_WAT_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_REQ;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_NEXT: begin
                w_tries_nxt = '0;
                if (r_zone == Z_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_zone_nxt  = r_zone + 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Dropping enable abandons the scan; no fault is recorded for it.
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_zone_nxt  = '0;
            w_tries_nxt = '0;
            w_timer_nxt = '0;
            w_fault_set = 1'b0;
        end
    end

    assign o_adc_start  = (r_state == S_REQ) && !r_zone_fault[r_zone];
    assign o_adc_ch     = r_zone;
    assign o_valve_en   = (r_state == S_OPEN || r_state == S_WATER) ? w_zone_onehot : '0;
    assign o_pump_on    = (r_state == S_WATER);
    assign o_busy       = (r_state != S_IDLE);
    assign o_scan_done  = (r_state == S_NEXT) && (r_zone == Z_LAST);
    assign o_overrun    = w_tick && (r_state != S_IDLE);
    assign o_zone_fault = r_zone_fault;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb/tb_irrigation_zone_scheduler.sv - scoreboard bench for irrigation_zone_scheduler
// Stimulus pushes expected events; a negedge monitor pops and compares as the DUT produces them.
module tb_irrigation_zone_scheduler;

    localparam int PERIOD = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_enable = 1'b0;
    logic [9:0] i_threshold = 10'd300;
    logic       i_fault_clr = 1'b0;
    logic       o_adc_start;
    logic [1:0] o_adc_ch;
    logic       i_adc_done = 1'b0;
    logic [9:0] i_adc_data = '0;
    logic [3:0] o_valve_en;
    logic       o_pump_on;
    logic       o_busy;
    logic       o_scan_done;
    logic       o_overrun;
    logic [3:0] o_zone_fault;

    irrigation_zone_scheduler #(
        .NUM_ZONES(4), .DATA_W(10), .PERIOD(PERIOD), .SETTLE(4),
        .WATER_CYCLES(8), .MAX_TRIES(2), .ADC_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_threshold(i_threshold),
        .i_fault_clr(i_fault_clr), .o_adc_start(o_adc_start), .o_adc_ch(o_adc_ch),
        .i_adc_done(i_adc_done), .i_adc_data(i_adc_data), .o_valve_en(o_valve_en),
        .o_pump_on(o_pump_on), .o_busy(o_busy), .o_scan_done(o_scan_done),
        .o_overrun(o_overrun), .o_zone_fault(o_zone_fault)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [3:0] v; int settle; int water; } valve_exp_t;
    typedef struct { logic [3:0] v; int lat; } fault_exp_t;
    typedef struct { int len; logic [3:0] f; } scan_exp_t;

    int         q_ch[$];
    valve_exp_t q_valve[$];
    fault_exp_t q_fault[$];
    int         q_ovr[$];
    scan_exp_t  q_scan[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int scen     = 0;

    logic [9:0] first_val [4];
    logic [9:0] later_val [4];
    logic [3:0] no_resp = 4'b0000;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
    endtask

    task automatic set_zone(input int ch, input int fv, input int lv);
        first_val[ch] = 10'(fv);
        later_val[ch] = 10'(lv);
    endtask

    task automatic push_ch(input int a, input int b, input int c, input int d);
        q_ch.push_back(a); q_ch.push_back(b); q_ch.push_back(c); q_ch.push_back(d);
    endtask

    task automatic push_valve(input logic [3:0] v, input int s, input int w);
        valve_exp_t e;
        e.v = v; e.settle = s; e.water = w;
        q_valve.push_back(e);
    endtask

    task automatic push_fault(input logic [3:0] v, input int lat);
        fault_exp_t e;
        e.v = v; e.lat = lat;
        q_fault.push_back(e);
    endtask

    task automatic push_scan(input int len, input logic [3:0] f);
        scan_exp_t e;
        e.len = len; e.f = f;
        q_scan.push_back(e);
    endtask

    task automatic wait_scan(input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (o_scan_done) seen = 1;
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    // Edge 1 is the first edge that samples enable (or reset low) with enable high.
    task automatic measure_first_tick(input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (o_adc_start) seen = 1;
        end
        chk(name, seen ? n : -1, PERIOD);
    endtask

    task automatic pulse_fault_clr();
        @(negedge clk) i_fault_clr = 1'b1;
        @(negedge clk) i_fault_clr = 1'b0;
    endtask

    initial forever @(posedge clk) cyc++;

    // ADC model: done strobe three cycles after adc_start unless the channel is mute.
    initial begin
        int dcnt = 0;
        int last_scen = -1;
        int conv_cnt [4];
        logic [9:0] pend_val = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dcnt = 0;
                i_adc_done = 1'b0;
            end else begin
                if (scen != last_scen) begin
                    last_scen = scen;
                    foreach (conv_cnt[k]) conv_cnt[k] = 0;
                end
                i_adc_done = 1'b0;
                if (dcnt != 0) begin
                    dcnt--;
                    if (dcnt == 0) begin
                        i_adc_done = 1'b1;
                        i_adc_data = pend_val;
                    end
                end
                if (o_adc_start && !no_resp[o_adc_ch]) begin
                    dcnt = 3;
                    pend_val = (conv_cnt[o_adc_ch] == 0) ? first_val[o_adc_ch] : later_val[o_adc_ch];
                    conv_cnt[o_adc_ch]++;
                end
            end
        end
    end

    initial begin
        int busy_cnt = 0;
        int last_start = 0;
        bit v_active = 0;
        logic [3:0] v_val = '0;
        int v_settle = 0;
        int v_water = 0;
        logic [3:0] prev_fault = '0;
        forever begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            else busy_cnt = 0;

            if ((o_zone_fault & ~prev_fault) != 4'b0000) begin
                if (q_fault.size() == 0) fail_evt("zone_fault_rise");
                else begin
                    fault_exp_t e;
                    e = q_fault.pop_front();
                    chk("zone_fault", int'(o_zone_fault), int'(e.v));
                    chk("fault_latency", cyc - last_start, e.lat);
                end
            end
            prev_fault = o_zone_fault;

            if (o_adc_start) begin
                last_start = cyc;
                if (q_ch.size() == 0) fail_evt("adc_start");
                else chk("adc_ch", int'(o_adc_ch), q_ch.pop_front());
            end

            if (o_pump_on && !$onehot(o_valve_en)) fail_evt("pump_without_single_valve");

            if (o_valve_en != 4'b0000) begin
                if (!v_active) begin
                    v_active = 1;
                    v_val = o_valve_en;
                    v_settle = 0;
                    v_water = 0;
                end
                if (o_pump_on) v_water++;
                else if (v_water == 0) v_settle++;
            end else if (v_active) begin
                v_active = 0;
                if (q_valve.size() == 0) fail_evt("valve_open");
                else begin
                    valve_exp_t e;
                    e = q_valve.pop_front();
                    chk("valve_en", int'(v_val), int'(e.v));
                    chk("settle_cycles", v_settle, e.settle);
                    chk("pump_cycles", v_water, e.water);
                end
            end

            if (o_overrun) begin
                if (q_ovr.size() == 0) fail_evt("overrun");
                else chk("overrun_at", busy_cnt, q_ovr.pop_front());
            end

            if (o_scan_done) begin
                if (q_scan.size() == 0) fail_evt("scan_done");
                else begin
                    scan_exp_t e;
                    e = q_scan.pop_front();
                    chk("scan_len", busy_cnt, e.len);
                    chk("scan_fault", int'(o_zone_fault), int'(e.f));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) set_zone(k, 500, 500);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_adc_start", int'(o_adc_start), 0);
        chk("rst_valve", int'(o_valve_en), 0);
        chk("rst_pump", int'(o_pump_on), 0);
        chk("rst_scan_done", int'(o_scan_done), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        chk("rst_zone_fault", int'(o_zone_fault), 0);
        @(negedge clk) reset = 1'b0;

        // All wet: each zone costs 1+3+1+1 = 6 cycles.
        scen = 1;
        push_ch(0, 1, 2, 3);
        push_scan(24, 4'b0000);
        @(negedge clk) i_enable = 1'b1;
        measure_first_tick("first_tick");
        wait_scan("scan_all_wet");

        // Zone 2 dry once, wet after one burst.
        scen = 2;
        set_zone(2, 200, 350);
        push_ch(0, 1, 2, 2);
        q_ch.push_back(3);
        push_valve(4'b0100, 4, 8);
        push_scan(41, 4'b0000);
        wait_scan("scan_single_dry");

        // Zone 1 stuck dry: two bursts, then fault.
        scen = 3;
        set_zone(2, 500, 500);
        set_zone(1, 100, 100);
        push_ch(0, 1, 1, 1);
        q_ch.push_back(2); q_ch.push_back(3);
        push_valve(4'b0010, 4, 8);
        push_valve(4'b0010, 4, 8);
        push_fault(4'b0010, 5);
        push_scan(58, 4'b0010);
        wait_scan("scan_stuck");

        // Faulted zone 1 skipped in 2 cycles.
        scen = 4;
        q_ch.push_back(0); q_ch.push_back(2); q_ch.push_back(3);
        push_scan(20, 4'b0010);
        wait_scan("scan_skip");

        scen = 5;
        set_zone(1, 500, 500);
        pulse_fault_clr();
        push_ch(0, 1, 2, 3);
        push_scan(24, 4'b0000);
        wait_scan("scan_after_clear");

        // Zone 0 mute, zone 3 stuck dry: 70-cycle scan overlaps the next tick.
        scen = 6;
        no_resp = 4'b0001;
        set_zone(3, 100, 100);
        push_ch(0, 1, 2, 3);
        q_ch.push_back(3); q_ch.push_back(3);
        push_fault(4'b0001, 17);
        push_valve(4'b1000, 4, 8);
        push_valve(4'b1000, 4, 8);
        q_ovr.push_back(64);
        push_fault(4'b1001, 5);
        push_scan(70, 4'b1001);
        wait_scan("scan_timeout_overrun");

        // Abort by enable during zone 3 watering.
        scen = 7;
        no_resp = 4'b0000;
        pulse_fault_clr();
        push_ch(0, 1, 2, 3);
        push_valve(4'b1000, 4, 3);
        begin
            int n = 0;
            while (!(o_pump_on && o_valve_en == 4'b1000) && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) chk("abort_wait_pump", 0, 1);
        end
        repeat (2) @(negedge clk);
        i_enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pump", int'(o_pump_on), 0);
        chk("abort_valve", int'(o_valve_en), 0);
        chk("abort_busy", int'(o_busy), 0);
        repeat (5) @(negedge clk);

        // Re-enable, then reset asynchronously while zone 0 settles.
        scen = 8;
        set_zone(3, 500, 500);
        set_zone(0, 100, 100);
        q_ch.push_back(0);
        push_valve(4'b0001, 2, 0);
        i_enable = 1'b1;
        measure_first_tick("tick_after_reenable");
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (o_valve_en != 4'b0001 && n < 100);
            if (n >= 100) chk("reset_wait_open", 0, 1);
        end
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_pump", int'(o_pump_on), 0);
        chk("reset_valve", int'(o_valve_en), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_zone_fault", int'(o_zone_fault), 0);
        @(negedge clk);
        reset = 1'b0;
        scen = 9;
        set_zone(0, 500, 500);
        push_ch(0, 1, 2, 3);
        push_scan(24, 4'b0000);
        measure_first_tick("tick_after_reset");
        wait_scan("scan_after_reset");

        repeat (4) @(negedge clk);
        chk("left_adc_ch", q_ch.size(), 0);
        chk("left_valve", q_valve.size(), 0);
        chk("left_fault", q_fault.size(), 0);
        chk("left_overrun", q_ovr.size(), 0);
        chk("left_scan", q_scan.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irrigation_zone_scheduler.md
# irrigation_zone_scheduler

Periodic multi-zone irrigation scheduler. It shares one soil-moisture ADC channel mux and one pump among `NUM_ZONES` valve-controlled zones. On each scan period it measures every zone in turn and waters any dry zone in bounded bursts, re-measuring after each burst. Zones that stay dry, and zones whose ADC does not respond, are latched as faulted and skipped until cleared. It sits between the ADC front end and the pump/valve drivers and replaces single-zone start/measure/control sequencing.

## Interface
- `NUM_ZONES`, 4: number of zones (2..16).
- `DATA_W`, 10: ADC sample width.
- `PERIOD`, 100000: cycles between scan starts (≥2).
- `SETTLE`, 64: cycles the valve is open before the pump starts (≥1).
- `WATER_CYCLES`, 50000: pump-on cycles per watering burst (≥1).
- `MAX_TRIES`, 3: watering bursts allowed per zone per scan (≥1).
- `ADC_TIMEOUT`, 1024: maximum wait cycles for `adc_done` (≥2).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `enable` in 1: scheduler run enable, level.
- `threshold` in DATA_W: dry threshold, unsigned; the zone is dry when sample < threshold.
- `fault_clr` in 1: synchronous clear of all `zone_fault` bits.
- `adc_start` out 1: single-cycle conversion request.
- `adc_ch` out clog2(NUM_ZONES): ADC channel, equal to the current zone index.
- `adc_done` in 1: conversion complete, single-cycle strobe.
- `adc_data` in DATA_W: sample, valid in the cycle `adc_done` is high.
- `valve_en` out NUM_ZONES: valve drive, one-hot or zero.
- `pump_on` out 1: pump drive.
- `busy` out 1: high when the state is not IDLE.
- `scan_done` out 1: one-cycle pulse when a scan completes.
- `overrun` out 1: one-cycle pulse when a period tick arrives while busy.
- `zone_fault` out NUM_ZONES: sticky per-zone fault flags.

## Operation
- States: IDLE, REQ, WAIT, EVAL, OPEN, WATER, NEXT. Held registers: zone index, tries, sample, timer, period counter.
- Period counter:
  - Held at 0 while `enable`=0.
  - Otherwise it counts 0..PERIOD-1 and wraps.
  - A tick occurs in the cycle the count equals PERIOD-1.
- IDLE: on tick go to REQ with zone=0 and tries=0. A tick in any other state pulses `overrun` and is otherwise ignored.
- REQ (1 cycle):
  - If `zone_fault[zone]` is set: go to NEXT with no `adc_start`.
  - Otherwise: assert `adc_start`, clear timer, go to WAIT.
- WAIT:
  - `adc_done`=1: latch `adc_data` and go to EVAL.
  - Otherwise, when timer reaches ADC_TIMEOUT-1: set `zone_fault[zone]` and go to NEXT.
- EVAL (1 cycle):
  - Wet (sample ≥ threshold): go to NEXT.
  - Dry and tries < MAX_TRIES: increment tries, go to OPEN.
  - Dry and tries = MAX_TRIES: set `zone_fault[zone]`, go to NEXT.
- OPEN: lasts SETTLE cycles with the valve open and the pump off, then go to WATER.
- WATER: lasts WATER_CYCLES cycles with the valve open and the pump on, then go to REQ for the same zone (re-measure).
- NEXT (1 cycle):
  - tries is cleared.
  - If zone = NUM_ZONES-1: pulse `scan_done` and go to IDLE.
  - Otherwise: zone increments, go to REQ.
- Output decode is Moore, from registered state:
  - `valve_en[zone]`=1 only in OPEN and WATER.
  - `pump_on`=1 only in WATER.
  - The pump is never on without exactly one valve open.
- `adc_ch` = zone in every state.
- `adc_done` outside WAIT is ignored.
- `enable` low in any state: next edge goes to IDLE. Valves, pump and `busy` are 0 from that edge. A scan in progress is abandoned, and the period counter resets.
- `fault_clr`: clears all fault bits at the next edge. If a set and the clear hit the same bit in the same cycle, the set wins.
- Threshold comparison is unsigned, at full DATA_W width. Counters are sized clog2 of their maximum; none wraps within a state.

## Timing
- Reset values:
  - State IDLE; zone, tries, timer, sample and period counter all 0.
  - `adc_start`, `valve_en`, `pump_on`, `busy`, `scan_done`, `overrun`, `zone_fault` all 0.
- First tick: PERIOD cycles after `enable` is first sampled high.
- `adc_start` is high in the cycle after the tick. `adc_done` is accepted from the cycle after `adc_start`.
- `adc_done` to EVAL: 1 cycle. EVAL to valve open: 1 cycle.
- Valve-open to pump-on: exactly SETTLE cycles.
- Pump and valve both drop on the same edge, when WATER moves to REQ.
- Wet zone (ADC latency L) cost: REQ 1 + WAIT L + EVAL 1 + NEXT 1.
- Faulted-zone skip cost: 2 cycles.
- Reset mid-operation takes effect immediately (asynchronous); all outputs return to their reset values.

## Test plan
Bench parameters for all scenarios: NUM_ZONES=4, PERIOD=64, SETTLE=4, WATER_CYCLES=8, MAX_TRIES=2, ADC_TIMEOUT=16, threshold=300.
- **All wet:** ADC returns 500 after 3 cycles on every channel.
  - Expect `adc_ch` sequence 0,1,2,3 with no valve or pump activity.
  - Expect `scan_done` 1 cycle after the zone-3 EVAL, with each zone's cycle cost matching the Timing formula.
- **Single dry zone:** zone 2 returns 200, then 350 after one burst.
  - Expect `valve_en`=4'b0100, with `pump_on` high 4 cycles later for 8 cycles.
  - Expect a re-measure on channel 2, no fault, and the scan to complete.
- **Stuck dry:** zone 1 always returns 100.
  - Expect two bursts, then `zone_fault`=4'b0010.
  - On the next scan, expect zone 1 skipped with no `adc_start` for channel 1.
  - Pulsing `fault_clr` restores measurement of zone 1.
- **ADC timeout and overrun:** no `adc_done` on channel 0.
  - Expect `zone_fault[0]` set 16 cycles after `adc_start`.
  - Inject a tick during a long burst and expect an `overrun` pulse with the scan unaffected.
- **Abort:** drop `enable` during WATER of zone 3, then separately assert `reset` mid-OPEN.
  - In both cases, expect `pump_on`, `valve_en` and `busy` at 0 by the next edge (reset: immediately).
  - After re-enable, expect the first tick 64 cycles later.
